imm_narrow: RTL and testbench
=============================

// Module: imm_narrow
// PURPOSE
//  Narrows a full-width constant into the I-bit immediate beats the ISA can
//  encode: the inverse of signext. A constant that fits the sign-extended
//  I-bit range goes out as one beat. Any other constant goes out as an
//  upper-half beat (lui) followed by a lower-half beat (ori).
//  Sits between the assembler/constant loader and the instruction builder.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  N  32     operand width in bits
//  I  N/2    immediate width; elaboration $error unless N == 2*I
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   in_data is presented
//  in_ready   out  1   block accepts in_data this cycle
//  in_data    in   N   constant to narrow
//  out_valid  out  1   out_imm/out_kind/out_last are valid
//  out_ready  in   1   downstream consumes the beat this cycle
//  out_imm    out  I   immediate field of this beat
//  out_kind   out  2   beat type: KIND_SEXT=0, KIND_HI=1, KIND_LO=2
//  out_last   out  1   final beat for this constant
// BEHAVIOUR
//  - Reset, async: state=S_IDLE, out_valid=0, out_imm=0, out_kind=KIND_SEXT,
//    out_last=0, held lower half=0. in_ready=0 while reset is high.
//  - fits = in_data[N-1:I-1] all ones or all zeros (imm_fit_check).
//  - in_ready = !reset && (state==S_IDLE || (out_valid && out_ready && out_last)).
//    This is combinational from out_ready and gives back-to-back throughput.
//  - Accept: in_valid && in_ready at edge t. The first beat is registered and
//    out_valid=1 from cycle t+1. Latency is 1 cycle.
//  - FSM (states S_IDLE, S_LAST, S_HI):
//    S_IDLE/accept, fits:  out_imm=in_data[I-1:0], kind=SEXT, last=1 -> S_LAST.
//    S_IDLE/accept, !fits: out_imm=in_data[N-1:I], kind=HI, last=0 -> S_HI;
//      in_data[I-1:0] is latched into the held lower half.
//    S_HI and out_ready: out_imm=held lower half, kind=LO, last=1 -> S_LAST.
//      The LO beat is zero-extended by the consumer (ori semantics).
//    S_LAST and out_ready: go to S_IDLE and drop out_valid, unless a new accept
//      happens in the same cycle. That accept loads its first beat directly
//      and takes the S_IDLE/accept transition.
//  - Stability: while out_valid && !out_ready, out_imm/out_kind/out_last hold
//    their values and the state does not advance.
//  - A constant is never dropped or duplicated. The HI beat always precedes
//    its LO beat, and beats of different constants never interleave.
//  - Boundaries: 0xFFFF8000 fits (SEXT 0x8000). 0x00008000 does not fit
//    (HI 0x0000 followed by LO 0x8000).
//  - Reset mid-sequence, e.g. in S_HI: the pending LO beat is discarded,
//    out_valid drops immediately, and nothing is emitted after release until
//    a new accept.
// CONFIGURATION
//  IMM_NARROW_SKIPLO_EN
//   defined: when !fits && in_data[I-1:0]==0, emit only the HI beat with
//     last=1 and go to S_LAST. S_HI is not entered.
//   undefined: such constants emit HI then LO 0x0000, as for any !fits value.
// STRUCTURE
//  imm_narrow_pkg: kind_t enum (KIND_SEXT, KIND_HI, KIND_LO, 2-bit),
//    state_t enum (S_IDLE, S_LAST, S_HI), localparam KIND_W=2.
//  Sub-module imm_fit_check #(N,I): combinational, in_data -> fits.
// TESTING
//  1 in 0x00001402, out_ready=1 -> cycle+1: SEXT 0x1402 last=1; in_ready=1.
//  2 in 0xFFFF8000 -> SEXT 0x8000 last=1.
//    in 0x00008000 -> HI 0x0000 last=0, then LO 0x8000 last=1.
//  3 in 0x12340000 -> HI 0x1234, then LO 0x0000 (macro off);
//    with IMM_NARROW_SKIPLO_EN -> HI 0x1234 last=1 only.
//  4 in 0xDEADBEEF with out_ready low for 3 cycles -> HI 0xDEAD held stable
//    and in_ready=0; after release, LO 0xBEEF.
//  5 stream 0x24B7, 0x00010000, 0xFFFFFFFF with in_valid and out_ready held
//    high -> beats SEXT 0x24B7 / HI 0x0001 / LO 0x0000 / SEXT 0xFFFF, no
//    bubble after each last beat.
//  6 in 0xCAFEF00D, assert reset during the HI beat -> out_valid=0
//    immediately; after release, no LO 0xF00D appears.

Source files
------------

// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: beat kinds, FSM states and widths shared by the immediate narrower.
package imm_narrow_pkg;
    localparam int KIND_W = 2;
    typedef enum logic [KIND_W-1:0] {
        KIND_SEXT = 2'd0,
        KIND_HI   = 2'd1,
        KIND_LO   = 2'd2
    } kind_t;
    typedef enum logic [1:0] {
        S_IDLE,
        S_LAST,
        S_HI
    } state_t;
endpackage

// File: rtl/imm_fit_check.sv
// imm_fit_check: flags a constant that survives narrowing to I bits and sign-extending back.
module imm_fit_check #(
    parameter int N = 32,
    parameter int I = N / 2
) (
    input  logic [N-1:0] in_data,
    output logic         fits
);
    // Equivalent to in_data[N-1:I-1] being all ones or all zeros.
    assign fits = in_data == {{(N-I){in_data[I-1]}}, in_data[I-1:0]};
endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: splits a full-width constant into one SEXT beat or a HI/LO beat pair.
// Optional macro IMM_NARROW_SKIPLO_EN drops the LO beat when the lower half is zero.
module imm_narrow
    import imm_narrow_pkg::*;
#(
    parameter int N = 32,
    parameter int I = N / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [I-1:0]      out_imm,
    output logic [KIND_W-1:0] out_kind,
    output logic              out_last
);
    state_t       state;
    logic [I-1:0] held;
    logic         fits;
    logic         skip_lo;
    logic         one_beat;
    logic         accept;

    if (N != 2 * I) begin : g_bad_width
        $error("imm_narrow: N must equal 2*I");
    end

    imm_fit_check #(.N(N), .I(I)) u_fit (.in_data(in_data), .fits(fits));

`ifdef IMM_NARROW_SKIPLO_EN
    assign skip_lo = ~|in_data[I-1:0];
`else
    assign skip_lo = 1'b0;
`endif

    always_comb begin
        one_beat = fits || skip_lo;
        in_ready = !reset && (state == S_IDLE || (out_valid && out_ready && out_last));
        accept   = in_valid && in_ready;
    end

    // A completing last beat and a new accept share one edge, so accept wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_kind  <= KIND_SEXT;
            out_last  <= 1'b0;
            held      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= fits ? in_data[I-1:0] : in_data[N-1:I];
            out_kind  <= fits ? KIND_SEXT : KIND_HI;
            out_last  <= one_beat;
            held      <= in_data[I-1:0];
            state     <= one_beat ? S_LAST : S_HI;
        end else if (out_valid && out_ready) begin
            if (state == S_HI) begin
                out_imm  <= held;
                out_kind <= KIND_LO;
                out_last <= 1'b1;
                state    <= S_LAST;
            end else begin
                out_valid <= 1'b0;
                state     <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: scoreboard bench for imm_narrow; expected beats are queued on accept.
module tb_imm_narrow;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_kind;
    logic        out_last;

    int total = 0;
    int bad = 0;
    logic [18:0] sb[$];

    imm_narrow #(.N(32), .I(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_kind(out_kind), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference split: beats packed as {imm, kind, last}.
    task automatic push_expect(input logic [31:0] d);
        logic signed [31:0] s;
        s = d;
        if (s >= -32768 && s <= 32767)
            sb.push_back({d[15:0], 2'd0, 1'b1});
`ifdef IMM_NARROW_SKIPLO_EN
        else if (d[15:0] == 16'h0)
            sb.push_back({d[31:16], 2'd1, 1'b1});
`endif
        else begin
            sb.push_back({d[31:16], 2'd1, 1'b0});
            sb.push_back({d[15:0], 2'd2, 1'b1});
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0)
                chk("spurious_beat", {out_imm, out_kind, out_last}, 32'h0);
            else
                chk("beat", {out_imm, out_kind, out_last}, sb.pop_front());
        end
        if (in_valid && in_ready)
            push_expect(in_data);
    end

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            if (k == 3)
                out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_kind", out_kind, 0);
        chk("rst_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);

        send(32'h0000_1402);
        in_valid = 1'b0;
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_imm", out_imm, 32'h1402);
        chk("t1_last", out_last, 1);
        chk("t1_in_ready", in_ready, 1);
        drain();

        send(32'hFFFF_8000);
        chk("t2_sext_kind", out_kind, 0);
        send(32'h0000_8000);
        in_valid = 1'b0;
        chk("t2_hi_kind", out_kind, 1);
        chk("t2_hi_last", out_last, 0);
        drain();

        send(32'h1234_0000);
        in_valid = 1'b0;
        chk("t3_hi_imm", out_imm, 32'h1234);
`ifdef IMM_NARROW_SKIPLO_EN
        chk("t3_hi_last", out_last, 1);
`else
        chk("t3_hi_last", out_last, 0);
`endif
        drain();

        out_ready = 1'b0;
        send(32'hDEAD_BEEF);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_imm", out_imm, 32'hDEAD);
            chk("t4_hold_kind", out_kind, 1);
            chk("t4_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        in_valid = 1'b1; in_data = 32'h0000_24B7;
        @(posedge clk); #1;
        in_data = 32'h0001_0000;
        #1 chk("t5_b0_valid", out_valid, 1);
        chk("t5_b0_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_data = 32'hFFFF_FFFF;
        #1 chk("t5_b1_valid", out_valid, 1);
        chk("t5_b1_in_ready", in_ready, 0);
        @(posedge clk); #1;
        #1 chk("t5_b2_valid", out_valid, 1);
        chk("t5_b2_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("t5_b3_valid", out_valid, 1);
        chk("t5_b3_imm", out_imm, 32'hFFFF);
        drain();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0: d = {16'h0000, 1'b0, 15'($urandom)};
                1: d = $urandom;
                2: d = {16'($urandom), 16'h0000};
                default: d = {16'hFFFF, 1'b1, 15'($urandom)};
            endcase
            out_ready = 1'($urandom_range(0, 1));
            send(d);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        send(32'hCAFE_F00D);
        in_valid = 1'b0;
        chk("t6_hi_kind", out_kind, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t6_quiet", out_valid, 0);
            @(posedge clk);
            #1;
        end

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
